// File: rtl/quan_scale_pkg.sv
// Shared constants, mode encodings and FSM state type for the tile E-scale loader.
package quan_scale_pkg;

  localparam int unsigned SCALE_WORD_WIDTH = 512;
  localparam int unsigned SCALE_WIDTH      = 8;
  localparam int unsigned SCALE_SET_WIDTH  = 16;
  localparam int unsigned SCALE_SETS_NUM   = 64;

  localparam logic [3:0] QUAN_SCALE_MODE_8B  = 4'd0;
  localparam logic [3:0] QUAN_SCALE_MODE_16B = 4'd1;

  // Registers covered by one scale word in each mode.
  localparam int unsigned SCALES_PER_WORD = SCALE_WORD_WIDTH / SCALE_WIDTH;
  localparam int unsigned SETS_PER_WORD   = SCALE_WORD_WIDTH / SCALE_SET_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDone
  } load_state_e;

endpackage

// File: rtl/quan_scale_loader.sv
// Pulls one or two scale words per tile command from an upstream stream and
// writes them into the tile E-scale register file, then pulses load_done.
module quan_scale_loader
  import quan_scale_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd_mode,
  input  logic [7:0]                  cmd_set_num,
  input  logic                        word_valid,
  output logic                        word_ready,
  input  logic [SCALE_WORD_WIDTH-1:0] word_data,
  output logic                        scale_set,
  output logic [3:0]                  mode,
  output logic [SCALE_WORD_WIDTH-1:0] scale_word,
  output logic [7:0]                  scale_reg_start,
  output logic [7:0]                  scale_reg_size,
  output logic                        load_done,
  output logic                        load_err
);

  localparam logic [7:0] SetsMax     = 8'(SCALE_SETS_NUM);
  localparam logic [7:0] SetsPerWord = 8'(SETS_PER_WORD);
  localparam logic [7:0] Word1Start  = 8'(SETS_PER_WORD + 1);

  load_state_e state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [7:0]  n_q, n_d;
  logic        w_q, w_d;
  logic        err_q, err_d;

  logic        word_hs;
  logic        last_word;
  logic        mode_ok;
  logic [7:0]  n_clamp;
  logic [7:0]  wr_size;

  always_comb begin
    n_clamp   = (cmd_set_num > SetsMax) ? SetsMax : cmd_set_num;
    mode_ok   = (cmd_mode == QUAN_SCALE_MODE_8B) || (cmd_mode == QUAN_SCALE_MODE_16B);
    cmd_ready = (state_q == StIdle);
    word_ready = (state_q == StFetch);
    word_hs   = word_valid && word_ready;
    // A second word exists only for 16-bit sets spilling past one word.
    last_word = (w_q == ((mode_q == QUAN_SCALE_MODE_16B) && (n_q > SetsPerWord)));

    if (mode_q == QUAN_SCALE_MODE_8B) begin
      wr_size = n_q;
    end else if (w_q) begin
      wr_size = n_q - SetsPerWord;
    end else begin
      wr_size = (n_q > SetsPerWord) ? SetsPerWord : n_q;
    end

    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    w_d     = w_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          mode_d = cmd_mode;
          n_d    = n_clamp;
          w_d    = 1'b0;
          // An empty load completes cleanly regardless of mode.
          err_d  = (n_clamp != 8'd0) && !mode_ok;
          if ((n_clamp == 8'd0) || !mode_ok) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (word_hs) begin
          if (last_word) begin
            state_d = StDone;
          end else begin
            w_d = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 4'd0;
      n_q     <= 8'd0;
      w_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      w_q     <= w_d;
      err_q   <= err_d;
    end
  end

  // Write interface and completion are registered; data holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_set       <= 1'b0;
      mode            <= 4'd0;
      scale_word      <= '0;
      scale_reg_start <= 8'd0;
      scale_reg_size  <= 8'd0;
      load_done       <= 1'b0;
      load_err        <= 1'b0;
    end else begin
      scale_set <= word_hs;
      if (word_hs) begin
        mode            <= mode_q;
        scale_word      <= word_data;
        scale_reg_start <= w_q ? Word1Start : 8'd1;
        scale_reg_size  <= wr_size;
      end
      load_done <= (state_q == StDone);
      load_err  <= (state_q == StDone) && err_q;
    end
  end

endmodule
